// File: rtl/flash_pkg.sv
// Shared opcodes, bit-group widths and FSM state type for the SPI flash burst reader.
package flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam logic [7:0] FLASH_CMD_WAKE = 8'hAB;

  localparam logic [5:0] FLASH_BITS_CMD  = 6'd8;
  localparam logic [5:0] FLASH_BITS_ADDR = 6'd24;
  localparam logic [5:0] FLASH_BITS_DATA = 6'd32;

  typedef enum logic [2:0] {
    StWakeCmd,
    StWakeWait,
    StIdle,
    StCmd,
    StAddr,
    StData,
    StCont,
    StDesel
  } flash_state_e;

  // Flash streams byte 0 first, so it ends up in the top of the shift register.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_spi_phy.sv
// SPI mode-0 bit engine: SCK divider plus MSB-first shifter for one 8/24/32-bit group.
module flash_spi_phy #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_start,
  input  logic [5:0]  i_width,
  input  logic [31:0] i_tx_data,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_busy,
  output logic        o_last,
  output logic        o_done,
  output logic [31:0] o_rx_data
);

  localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

  logic [7:0]  r_div;
  logic [5:0]  r_bits;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_busy;
  logic        r_done;

  logic        w_tick;
  logic [31:0] w_aligned;

  assign w_tick    = r_busy && (r_div == DivMax);
  // o_last marks the falling edge that ends the group; a start in the same cycle chains seamlessly.
  assign o_last    = w_tick && r_sclk && (r_bits == 6'd1);
  assign w_aligned = i_tx_data << (6'd32 - i_width);

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_div  <= '0;
      r_bits <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= o_last && !i_start;
      if (i_start) begin
        r_tx   <= w_aligned << 1;
        r_mosi <= w_aligned[31];
        r_bits <= i_width;
        r_div  <= '0;
        r_sclk <= 1'b0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_tick) begin
          r_div <= '0;
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[30:0], i_miso};
          end else begin
            r_sclk <= 1'b0;
            if (r_bits == 6'd1) begin
              r_busy <= 1'b0;
              r_mosi <= 1'b0;
            end else begin
              r_mosi <= r_tx[31];
              r_tx   <= r_tx << 1;
              r_bits <= r_bits - 6'd1;
            end
          end
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx;

endmodule

// File: rtl/spi_flash_burst_reader.sv
// Streams 32-bit words from SPI flash using READ, keeping CS low across sequential addresses.
module spi_flash_burst_reader
  import flash_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned WAKE_CYCLES    = 64,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [15:0] WakeLoad  = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] DeselLoad = 16'(CS_HIGH_CYCLES - 1);

  flash_state_e r_state;
  logic [23:0]  r_cur_addr;
  logic [15:0]  r_cnt;
  logic         r_spi_cs;
  logic         r_ready;
  logic [31:0]  r_rdata;

  logic         w_start;
  logic [5:0]   w_width;
  logic [31:0]  w_tx;
  logic         w_busy;
  logic         w_last;
  logic         w_done;
  logic [31:0]  w_rx;
  logic [23:0]  w_addr_aligned;
  logic         w_seq;

  assign w_addr_aligned = addr & 24'hFFFFFC;
  assign w_seq          = valid && (w_addr_aligned == r_cur_addr);

  flash_spi_phy #(
    .CLK_DIV(CLK_DIV)
  ) u_phy (
    .i_clock  (clock),
    .i_resetn (resetn),
    .i_start  (w_start),
    .i_width  (w_width),
    .i_tx_data(w_tx),
    .i_miso   (spi_miso),
    .o_sclk   (spi_sclk),
    .o_mosi   (spi_mosi),
    .o_busy   (w_busy),
    .o_last   (w_last),
    .o_done   (w_done),
    .o_rx_data(w_rx)
  );

  // Command, address and data groups are chained on o_last so SCK never pauses between them.
  always_comb begin
    w_start = 1'b0;
    w_width = FLASH_BITS_CMD;
    w_tx    = '0;
    unique case (r_state)
      StWakeCmd: begin
        if (!r_spi_cs && !w_busy && !w_done) begin
          w_start = 1'b1;
          w_tx    = {24'd0, FLASH_CMD_WAKE};
        end
      end
      StCmd: begin
        if (w_last) begin
          w_start = 1'b1;
          w_width = FLASH_BITS_ADDR;
          w_tx    = {8'd0, r_cur_addr};
        end else if (!w_busy && !w_done) begin
          w_start = 1'b1;
          w_tx    = {24'd0, FLASH_CMD_READ};
        end
      end
      StAddr: begin
        if (w_last) begin
          w_start = 1'b1;
          w_width = FLASH_BITS_DATA;
        end
      end
      StCont: begin
        if (w_seq) begin
          w_start = 1'b1;
          w_width = FLASH_BITS_DATA;
        end
      end
      StWakeWait, StIdle, StData, StDesel: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= StWakeCmd;
      r_cur_addr <= '0;
      r_cnt      <= '0;
      r_spi_cs   <= 1'b1;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        StWakeCmd: begin
          if (w_done) begin
            r_spi_cs <= 1'b1;
            r_cnt    <= WakeLoad;
            r_state  <= StWakeWait;
          end else begin
            r_spi_cs <= 1'b0;
          end
        end
        StWakeWait: begin
          if (r_cnt == 16'd0) r_state <= StIdle;
          else r_cnt <= r_cnt - 16'd1;
        end
        StIdle: begin
          if (valid) begin
            r_cur_addr <= w_addr_aligned;
            r_spi_cs   <= 1'b0;
            r_state    <= StCmd;
          end
        end
        StCmd: begin
          if (w_last) r_state <= StAddr;
        end
        StAddr: begin
          if (w_last) r_state <= StData;
        end
        StData: begin
          if (w_done) begin
            r_rdata    <= byte_swap32(w_rx);
            r_ready    <= 1'b1;
            r_cur_addr <= r_cur_addr + 24'd4;
            r_state    <= StCont;
          end
        end
        StCont: begin
          if (w_seq) begin
            r_state <= StData;
          end else begin
            r_spi_cs <= 1'b1;
            r_cnt    <= DeselLoad;
            r_state  <= StDesel;
          end
        end
        StDesel: begin
          if (r_cnt == 16'd0) r_state <= StIdle;
          else r_cnt <= r_cnt - 16'd1;
        end
      endcase
    end
  end

  assign spi_cs = r_spi_cs;
  assign ready  = r_ready;
  assign rdata  = r_rdata;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench: behavioural READ-capable flash model plus hand-derived timing expectations.
module tb_spi_flash_burst_reader;

  logic        clock = 1'b0;
  logic        resetn;
  logic        valid;
  logic [23:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  spi_flash_burst_reader #(
    .CLK_DIV       (1),
    .WAKE_CYCLES   (64),
    .CS_HIGH_CYCLES(4)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .valid   (valid),
    .ready   (ready),
    .addr    (addr),
    .rdata   (rdata),
    .spi_cs  (spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    case (a)
      24'h100000: return 8'h11;
      24'h100001: return 8'h22;
      24'h100002: return 8'h33;
      24'h100003: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    logic [23:0] a1, a2, a3;
    a1 = a + 24'd1;
    a2 = a + 24'd2;
    a3 = a + 24'd3;
    return {byte_at(a3), byte_at(a2), byte_at(a1), byte_at(a)};
  endfunction

  // Flash model: records each CS-low session's opcode/address, returns data after a READ.
  logic [7:0]  txn_op[$];
  logic [23:0] txn_addr[$];
  int          fm_nbits = 0;
  int          fm_out_bit = 0;
  logic [31:0] fm_sh = '0;
  logic [7:0]  fm_op = '0;
  logic [7:0]  fm_byte;
  logic [23:0] fm_addr = '0;
  logic [23:0] fm_out_addr = '0;

  always @(posedge spi_sclk or negedge spi_sclk or posedge spi_cs) begin
    if (spi_cs === 1'b1) begin
      if (fm_nbits > 0) begin
        txn_op.push_back(fm_op);
        txn_addr.push_back(fm_addr);
      end
      fm_nbits = 0;
      fm_sh    = '0;
      fm_op    = '0;
      fm_addr  = '0;
    end else if (spi_sclk === 1'b1) begin
      fm_sh = {fm_sh[30:0], spi_mosi};
      fm_nbits++;
      if (fm_nbits == 8) fm_op = fm_sh[7:0];
      if (fm_nbits == 32) begin
        fm_addr     = fm_sh[23:0];
        fm_out_addr = fm_sh[23:0];
        fm_out_bit  = 0;
      end
    end else if (fm_nbits >= 32 && fm_op == 8'h03) begin
      fm_byte  = byte_at(fm_out_addr);
      spi_miso = fm_byte[7 - fm_out_bit];
      if (fm_out_bit == 7) begin
        fm_out_bit  = 0;
        fm_out_addr = fm_out_addr + 24'd1;
      end else begin
        fm_out_bit++;
      end
    end
  end

  logic prev_cs = 1'b1;
  int   cs_fall_cnt = 0;
  int   cs_rise_cnt = 0;
  int   cs_fall_cyc = 0;
  int   high_run = 0;
  int   last_high_len = 0;
  int   ready_cnt = 0;

  always @(negedge clock) begin
    if (prev_cs && !spi_cs) begin
      cs_fall_cnt++;
      cs_fall_cyc   = cyc;
      last_high_len = high_run;
    end
    if (!prev_cs && spi_cs) begin
      cs_rise_cnt++;
      high_run = 0;
    end
    if (spi_cs) high_run++;
    if (ready === 1'b1) ready_cnt++;
    prev_cs = spi_cs;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int max_cyc, output int t);
    logic seen;
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clock);
      if (ready === 1'b1) begin
        seen = 1'b1;
        t    = cyc;
      end
    end
    check_eq("ready_seen", 64'(seen), 64'd1);
  endtask

  int e1, t0, t1, falls0, rises0, rc, n0;

  initial begin
    resetn = 1'b0;
    valid  = 1'b1;
    addr   = 24'h100000;
    repeat (3) @(negedge clock);
    check_eq("rst_cs",    64'(spi_cs),   64'd1);
    check_eq("rst_sclk",  64'(spi_sclk), 64'd0);
    check_eq("rst_mosi",  64'(spi_mosi), 64'd0);
    check_eq("rst_ready", 64'(ready),    64'd0);
    check_eq("rst_rdata", 64'(rdata),    64'd0);

    // Wake then single read, valid held high from reset onwards.
    resetn = 1'b1;
    e1     = cyc + 1;
    wait_ready(600, t0);
    valid = 1'b0;
    check_eq("first_ready_cyc", 64'(t0 - e1), 64'd213);
    check_eq("first_latency",   64'(t0 - cs_fall_cyc), 64'd130);
    check_eq("wake_cs_high",    64'(last_high_len >= 64), 64'd1);
    check_eq("rd1_data",        64'(rdata), 64'h44332211);
    @(negedge clock);
    check_eq("ready_one_cycle", 64'(ready), 64'd0);
    repeat (20) @(negedge clock);
    check_eq("wake_op",   64'(txn_op[0]),   64'hAB);
    check_eq("rd1_op",    64'(txn_op[1]),   64'h03);
    check_eq("rd1_addr",  64'(txn_addr[1]), 64'h100000);
    check_eq("rd1_count", 64'(ready_cnt),   64'd1);
    check_eq("rd1_hold",  64'(rdata),       64'h44332211);

    // Sequential stream of four words under one command.
    falls0 = cs_fall_cnt;
    rises0 = cs_rise_cnt;
    valid  = 1'b1;
    addr   = 24'h100000;
    for (int i = 0; i < 4; i++) begin
      wait_ready(300, t1);
      check_eq("stream_data", 64'(rdata), 64'(word_at(24'h100000 + 24'(4 * i))));
      if (i > 0) check_eq("stream_spacing", 64'(t1 - t0), 64'd66);
      t0 = t1;
      if (i < 3) addr = addr + 24'd4;
      else valid = 1'b0;
    end
    check_eq("stream_one_cmd", 64'(cs_fall_cnt - falls0), 64'd1);
    check_eq("stream_no_desel", 64'(cs_rise_cnt - rises0), 64'd0);
    repeat (20) @(negedge clock);
    check_eq("stream_addr", 64'(txn_addr[$]), 64'h100000);

    // Non-sequential jump after 0x100004.
    valid = 1'b1;
    addr  = 24'h100000;
    wait_ready(300, t0);
    addr = 24'h100004;
    wait_ready(300, t0);
    addr = 24'h200000;
    wait_ready(400, t1);
    valid = 1'b0;
    check_eq("jump_data",    64'(rdata), 64'(word_at(24'h200000)));
    check_eq("jump_spacing", 64'(t1 - t0), 64'd136);
    check_eq("jump_cs_high", 64'(last_high_len >= 4), 64'd1);
    repeat (20) @(negedge clock);
    check_eq("jump_op",   64'(txn_op[$]),   64'h03);
    check_eq("jump_addr", 64'(txn_addr[$]), 64'h200000);

    // Sequential wrap from the top of the 24-bit space.
    falls0 = cs_fall_cnt;
    valid  = 1'b1;
    addr   = 24'hFFFFFC;
    wait_ready(300, t0);
    check_eq("wrap_data0", 64'(rdata), 64'(word_at(24'hFFFFFC)));
    addr = 24'h000000;
    wait_ready(300, t1);
    valid = 1'b0;
    check_eq("wrap_data1",   64'(rdata), 64'(word_at(24'h000000)));
    check_eq("wrap_spacing", 64'(t1 - t0), 64'd66);
    check_eq("wrap_one_cmd", 64'(cs_fall_cnt - falls0), 64'd1);
    repeat (20) @(negedge clock);
    check_eq("wrap_addr", 64'(txn_addr[$]), 64'hFFFFFC);

    // Reset pulsed in the middle of a data group.
    valid = 1'b1;
    addr  = 24'h100000;
    for (int i = 0; i < 50 && spi_cs; i++) @(negedge clock);
    check_eq("rst_mid_cs_fell", 64'(spi_cs), 64'd0);
    repeat (80) @(negedge clock);
    rc     = ready_cnt;
    n0     = txn_op.size();
    resetn = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_cs",    64'(spi_cs),   64'd1);
    check_eq("rst_mid_sclk",  64'(spi_sclk), 64'd0);
    check_eq("rst_mid_ready", 64'(ready),    64'd0);
    resetn = 1'b1;
    e1     = cyc + 1;
    wait_ready(600, t0);
    valid = 1'b0;
    check_eq("rst_mid_rewake_cyc", 64'(t0 - e1), 64'd213);
    check_eq("rst_mid_data",       64'(rdata), 64'h44332211);
    repeat (20) @(negedge clock);
    check_eq("rst_mid_wake_op",  64'(txn_op[n0 + 1]), 64'hAB);
    check_eq("rst_mid_ready_cnt", 64'(ready_cnt - rc), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
